// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_trace_buffer
//  Purpose  : Execution trace recorder for the multicycle CPU. Qualified
//             debug events are snapshotted into a circular FIFO once an
//             optional PC trigger fires. A consumer drains the FIFO through
//             a valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, reset          : rising-edge clock, async active-high reset
//    cpu_pc/estado/ula_out : CPU debug snapshot sources
//    cpu_reg_wr/memoria_wr : write enables (event sources)
//    cpu_ld_ir/overflow    : recorded status bits
//    arm / stop            : control pulses (flush+arm / return to idle)
//    trig_en / trig_pc     : PC trigger enable and value
//    cap_mask              : event qualifiers {memoria_wr, reg_wr, state chg}
//    rd_valid/ready/data   : FIFO read handshake, data shows head entry
//    count                 : FIFO occupancy
//    drop_cnt              : saturating count of events lost while full
//    trace_state           : IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3
// ============================================================================
module cpu_trace_buffer #(
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              cpu_pc,
    input  logic [4:0]               cpu_estado,
    input  logic [31:0]              cpu_ula_out,
    input  logic                     cpu_reg_wr,
    input  logic                     cpu_memoria_wr,
    input  logic                     cpu_ld_ir,
    input  logic                     cpu_overflow,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     trig_en,
    input  logic [31:0]              trig_pc,
    input  logic [2:0]               cap_mask,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [72:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              drop_cnt,
    output logic [1:0]               trace_state
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [15:0] POST_LIM = 16'(POST_CNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [15:0]     drop_q;
    logic [15:0]     post_q;
    logic [4:0]      prev_estado_q;
    logic [72:0]     mem_q [DEPTH];

    logic            state_chg;
    logic            event_w;
    logic            rec_window;
    logic            wr_req;
    logic            full;
    logic            rd_fire;
    logic            wr_ok;
    logic            drop_ev;
    logic            freeze_hit;
    logic            flush;
    logic [72:0]     entry;

    assign state_chg = (cpu_estado != prev_estado_q);
    assign event_w   = (cap_mask[0] & state_chg) |
                       (cap_mask[1] & cpu_reg_wr) |
                       (cap_mask[2] & cpu_memoria_wr);

    assign entry = {cpu_overflow, cpu_ld_ir, cpu_reg_wr, cpu_memoria_wr,
                    cpu_estado, cpu_pc, cpu_ula_out};

    assign full     = (count_q == CW'(DEPTH));
    assign rd_valid = (count_q != '0);
    assign rd_fire  = rd_valid & rd_ready;
    // Control pulses take the cycle: no recording while arming or stopping.
    assign wr_req   = rec_window & event_w & ~arm & ~stop;
    assign wr_ok    = wr_req & (~full | rd_fire);
    assign drop_ev  = wr_req & full & ~rd_fire;
    assign flush    = arm & ~stop;

    // The event that brings the post counter to its limit is the last one.
    assign freeze_hit = (POST_CNT != 0) && event_w &&
                        ((post_q + 16'd1) == POST_LIM);

    always_comb begin
        state_d    = state_q;
        rec_window = 1'b0;
        case (state_q)
            ST_ARMED: begin
                // The trigger cycle itself is recorded.
                if (!trig_en || (cpu_pc == trig_pc)) begin
                    rec_window = 1'b1;
                    state_d    = freeze_hit ? ST_FROZEN : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rec_window = 1'b1;
                if (freeze_hit) begin
                    state_d = ST_FROZEN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (arm) begin
            state_d = ST_ARMED;
        end
        if (stop) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            drop_q        <= '0;
            post_q        <= '0;
            prev_estado_q <= '0;
        end else begin
            prev_estado_q <= cpu_estado;
            state_q       <= state_d;
            if (flush) begin
                // Flush wins over a same-cycle read.
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                drop_q   <= '0;
                post_q   <= '0;
            end else begin
                if (wr_ok) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (rd_fire) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                case ({wr_ok, rd_fire})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
                if (drop_ev && (drop_q != 16'hFFFF)) begin
                    drop_q <= drop_q + 16'd1;
                end
                // Counts every qualified event, recorded or dropped.
                if (wr_req) begin
                    post_q <= post_q + 16'd1;
                end
            end
        end
    end

    // Storage array carries no reset; the output mask hides stale contents.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count       = count_q;
    assign drop_cnt    = drop_q;
    assign trace_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_trace_buffer
//  Purpose  : Directed self-checking bench for cpu_trace_buffer. Two
//             instances share stimulus: u_dut0 (POST_CNT=8) and u_dut1
//             (POST_CNT=0, never freezes).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] cpu_pc;
    logic [4:0]  cpu_estado;
    logic [31:0] cpu_ula_out;
    logic        cpu_reg_wr, cpu_memoria_wr, cpu_ld_ir, cpu_overflow;
    logic        arm, stop, trig_en;
    logic [31:0] trig_pc;
    logic [2:0]  cap_mask;
    logic        rd_ready;

    logic        rd_valid0, rd_valid1;
    logic [72:0] rd_data0, rd_data1;
    logic [4:0]  count0, count1;
    logic [15:0] drop0, drop1;
    logic [1:0]  st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    cpu_trace_buffer #(.DEPTH(16), .POST_CNT(8)) u_dut0 (
        .clock(clock), .reset(reset), .cpu_pc(cpu_pc), .cpu_estado(cpu_estado),
        .cpu_ula_out(cpu_ula_out), .cpu_reg_wr(cpu_reg_wr),
        .cpu_memoria_wr(cpu_memoria_wr), .cpu_ld_ir(cpu_ld_ir),
        .cpu_overflow(cpu_overflow), .arm(arm), .stop(stop), .trig_en(trig_en),
        .trig_pc(trig_pc), .cap_mask(cap_mask), .rd_valid(rd_valid0),
        .rd_ready(rd_ready), .rd_data(rd_data0), .count(count0),
        .drop_cnt(drop0), .trace_state(st0)
    );

    cpu_trace_buffer #(.DEPTH(16), .POST_CNT(0)) u_dut1 (
        .clock(clock), .reset(reset), .cpu_pc(cpu_pc), .cpu_estado(cpu_estado),
        .cpu_ula_out(cpu_ula_out), .cpu_reg_wr(cpu_reg_wr),
        .cpu_memoria_wr(cpu_memoria_wr), .cpu_ld_ir(cpu_ld_ir),
        .cpu_overflow(cpu_overflow), .arm(arm), .stop(stop), .trig_en(trig_en),
        .trig_pc(trig_pc), .cap_mask(cap_mask), .rd_valid(rd_valid1),
        .rd_ready(rd_ready), .rd_data(rd_data1), .count(count1),
        .drop_cnt(drop1), .trace_state(st1)
    );

    task automatic check_eq(input string tag, input logic [72:0] obs,
                            input logic [72:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [72:0] pack(input logic rw, input logic [4:0] est,
                                         input logic [31:0] pc,
                                         input logic [31:0] ula);
        return {1'b0, 1'b0, rw, 1'b0, est, pc, ula};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; cpu_pc = '0; cpu_estado = '0; cpu_ula_out = '0;
        cpu_reg_wr = 0; cpu_memoria_wr = 0; cpu_ld_ir = 0; cpu_overflow = 0;
        arm = 0; stop = 0; trig_en = 0; trig_pc = '0; cap_mask = '0;
        rd_ready = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset values
        check_eq("rst_state", 73'(st0), 73'd0);
        check_eq("rst_count", 73'(count0), 73'd0);
        check_eq("rst_valid", 73'(rd_valid0), 73'd0);
        check_eq("rst_data", rd_data0, 73'd0);
        check_eq("rst_drop", 73'(drop0), 73'd0);

        // Test 1: state-change capture, immediate trigger
        cap_mask = 3'b001; trig_en = 0; arm = 1; cpu_estado = 5'd0;
        step();
        arm = 0;
        check_eq("t1_armed", 73'(st0), 73'd1);
        step();
        check_eq("t1_capture", 73'(st0), 73'd2);
        check_eq("t1_empty", 73'(rd_valid0), 73'd0);
        cpu_estado = 5'd1; step();
        check_eq("t1_valid_lat", 73'(rd_valid0), 73'd1);
        cpu_estado = 5'd2; step();
        cpu_estado = 5'd3; step();
        step();
        check_eq("t1_count", 73'(count0), 73'd3);
        rd_ready = 1;
        for (int k = 1; k <= 3; k++) begin
            check_eq("t1_data", rd_data0, pack(1'b0, 5'(k), 32'h0, 32'h0));
            step();
        end
        rd_ready = 0;
        check_eq("t1_drained", 73'(rd_valid0), 73'd0);

        // Test 2: PC trigger, freeze after 8 events
        cpu_estado = 5'd0; cap_mask = 3'b010; trig_en = 1;
        trig_pc = 32'h10; cpu_pc = 32'h0; arm = 1;
        step();
        arm = 0; cpu_reg_wr = 1;
        cpu_pc = 32'h0; step();
        cpu_pc = 32'h4; step();
        cpu_pc = 32'h8; step();
        check_eq("t2_pretrig_state", 73'(st0), 73'd1);
        check_eq("t2_pretrig_count", 73'(count0), 73'd0);
        cpu_pc = 32'h10; step();
        check_eq("t2_trig_state", 73'(st0), 73'd2);
        check_eq("t2_trig_count", 73'(count0), 73'd1);
        for (int i = 1; i <= 7; i++) begin
            cpu_pc = 32'h10 + 32'(4 * i);
            step();
        end
        check_eq("t2_frozen", 73'(st0), 73'd3);
        check_eq("t2_count8", 73'(count0), 73'd8);
        step();
        check_eq("t2_frozen_hold", 73'(count0), 73'd8);
        cpu_reg_wr = 0;
        check_eq("t2_first_pc", rd_data0, pack(1'b1, 5'd0, 32'h10, 32'h0));

        // Test 3: overflow on the never-freeze instance
        cpu_pc = 32'h0; trig_en = 0; arm = 1;
        step();
        arm = 0;
        for (int i = 0; i < 20; i++) begin
            cpu_reg_wr = 1; cpu_ula_out = 32'(i);
            step();
        end
        cpu_reg_wr = 0;
        check_eq("t3_count", 73'(count1), 73'd16);
        check_eq("t3_drop", 73'(drop1), 73'd4);
        check_eq("t3_state", 73'(st1), 73'd2);

        // Test 4: full FIFO, read and write in the same cycle
        cpu_reg_wr = 1; cpu_ula_out = 32'd100; rd_ready = 1;
        check_eq("t4_head", rd_data1, pack(1'b1, 5'd0, 32'h0, 32'd0));
        step();
        cpu_reg_wr = 0; rd_ready = 0;
        check_eq("t4_count", 73'(count1), 73'd16);
        check_eq("t4_drop", 73'(drop1), 73'd4);
        for (int k = 0; k < 16; k++) begin
            check_eq("t4_drain", rd_data1,
                     pack(1'b1, 5'd0, 32'h0, (k < 15) ? 32'(k + 1) : 32'd100));
            rd_ready = 1; step(); rd_ready = 0;
        end
        check_eq("t4_empty", 73'(rd_valid1), 73'd0);

        // Test 5: asynchronous reset mid-capture
        arm = 1; step(); arm = 0;
        for (int i = 1; i <= 5; i++) begin
            cpu_reg_wr = 1; cpu_ula_out = 32'(i);
            step();
        end
        cpu_reg_wr = 0;
        check_eq("t5_count5", 73'(count0), 73'd5);
        check_eq("t5_capture", 73'(st0), 73'd2);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_count", 73'(count0), 73'd0);
        check_eq("t5_rst_valid", 73'(rd_valid0), 73'd0);
        check_eq("t5_rst_state", 73'(st0), 73'd0);
        check_eq("t5_rst_data", rd_data0, 73'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Test 6: stop retains contents, blocks further recording
        arm = 1; step(); arm = 0;
        for (int i = 1; i <= 3; i++) begin
            cpu_reg_wr = 1; cpu_ula_out = 32'(i);
            step();
        end
        cpu_ula_out = 32'd4; stop = 1; step(); stop = 0;
        for (int i = 5; i <= 7; i++) begin
            cpu_ula_out = 32'(i);
            step();
        end
        cpu_reg_wr = 0;
        check_eq("t6_idle", 73'(st0), 73'd0);
        check_eq("t6_count", 73'(count0), 73'd3);
        for (int k = 1; k <= 3; k++) begin
            check_eq("t6_drain", rd_data0, pack(1'b1, 5'd0, 32'h0, 32'(k)));
            rd_ready = 1; step(); rd_ready = 0;
        end
        check_eq("t6_empty", 73'(rd_valid0), 73'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Hardware trace recorder downstream of the multicycle CPU. It consumes the CPU debug outputs: PC, state, ULA result, write enables, IR load and overflow. Qualified events are packed into a circular FIFO after an optional PC trigger. A host, the bench or a later UART dump block, drains the FIFO over a valid/ready handshake, so execution history survives after simulation or on hardware.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
POST_CNT, 8, events recorded after trigger before freezing; 0 means never freeze.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_pc  in  32  CPU Pc_Out[31:0]
cpu_estado  in  5  CPU control state
cpu_ula_out  in  32  ULA result [31:0]
cpu_reg_wr  in  1  register-file write enable
cpu_memoria_wr  in  1  data-memory write enable
cpu_ld_ir  in  1  instruction-register load
cpu_overflow  in  1  ULA overflow
arm  in  1  pulse: flush FIFO and drop count, enter ARMED
stop  in  1  pulse: return to IDLE, FIFO contents retained
trig_en  in  1  1 = wait for trig_pc; 0 = trigger immediately on arm
trig_pc  in  32  trigger PC value
cap_mask  in  3  bit0 state change, bit1 reg_wr, bit2 memoria_wr
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer accepts head entry
rd_data  out  73  {overflow, ld_ir, reg_wr, memoria_wr, estado[4:0], pc[31:0], ula_out[31:0]}
count  out  log2(DEPTH)+1  current occupancy
drop_cnt  out  16  events lost while full, saturates at 16'hFFFF
trace_state  out  2  IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3

Behaviour:
- Reset values: trace_state=IDLE, FIFO empty, count=0, rd_valid=0, rd_data=0, drop_cnt=0, post counter=0, prev_estado register=0.
- prev_estado updates every cycle, in all states, to cpu_estado.
- State change is defined as cpu_estado != prev_estado.
- Event is defined as (cap_mask[0] & state change) | (cap_mask[1] & cpu_reg_wr) | (cap_mask[2] & cpu_memoria_wr).
- FSM transitions, with stop having highest priority, then arm:
  - stop: next state IDLE from any state.
  - arm, any state: next state ARMED. Same edge clears FIFO pointers, count, drop_cnt and the post counter.
  - ARMED -> CAPTURE when trig_en=0, or when cpu_pc==trig_pc. The trigger cycle is itself eligible for recording.
  - CAPTURE -> FROZEN when POST_CNT!=0 and the post counter reaches POST_CNT. The post counter increments on every event, recorded or dropped.
  - IDLE and FROZEN hold until arm.
- Recording happens only in CAPTURE, plus the ARMED trigger cycle.
  - The entry is the same-cycle snapshot of the cpu_* inputs.
  - It is written at the rising edge; the latency from event to rd_valid is 1 cycle.
- Full FIFO (count==DEPTH) with an event:
  - If a read fires in the same cycle, the write is accepted and count is unchanged.
  - Otherwise the entry is dropped and drop_cnt increments (saturating).
- Read fire is rd_valid & rd_ready. rd_data shows the head combinationally from the FIFO array; the pointer advances on fire.
- Simultaneous read and write when non-full: both occur, count unchanged.
- Pointers wrap modulo DEPTH.
- Reads are allowed in every state, including IDLE and FROZEN.
- An arm in the same cycle as a read fire: the flush wins and the read is discarded.
- Reset asserted mid-capture returns immediately (asynchronously) to the reset values.

Test Plan:
- Reset then arm with trig_en=0, cap_mask=3'b001, cpu_estado stepping 0,1,2,3 over 4 cycles -> 3 entries with estado 1,2,3; rd_valid rises 1 cycle after the first change.
- trig_en=1, trig_pc=32'h0000_0010, PC sequence 0,4,8,0x10 with cpu_reg_wr held 1 and cap_mask=3'b010 -> no entries before PC 0x10; first entry has pc=0x10; FROZEN after 8 events.
- DEPTH=16, rd_ready=0, 20 reg_wr events with POST_CNT=0 -> count=16, drop_cnt=4. Draining 16 entries returns them in order.
- Full FIFO with rd_ready=1 and an event in the same cycle -> count stays 16, drop_cnt unchanged, new entry at the tail.
- Assert reset mid-CAPTURE after 5 entries -> count=0, rd_valid=0, trace_state=0 immediately, before the next clock edge.
- Pulse stop in CAPTURE with 3 entries, then drain -> trace_state=0, all 3 entries readable, no new entries despite events.
